// File: rtl/mc_speed_pkg.sv
// Shared types and Hall code helpers for the speed core.
package mc_speed_pkg;

  typedef enum logic [1:0] {StIdle, StSync, StRun, StStall} ch_state_e;

  localparam logic [2:0] Hall0 = 3'b001;
  localparam logic [2:0] Hall1 = 3'b011;
  localparam logic [2:0] Hall2 = 3'b010;
  localparam logic [2:0] Hall3 = 3'b110;
  localparam logic [2:0] Hall4 = 3'b100;
  localparam logic [2:0] Hall5 = 3'b101;

  function automatic logic code_valid(input logic [2:0] code);
    return (code != 3'b000) && (code != 3'b111);
  endfunction

  // Invalid codes map to themselves so they never look adjacent.
  function automatic logic [2:0] fwd_next(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      Hall0:   nxt = Hall1;
      Hall1:   nxt = Hall2;
      Hall2:   nxt = Hall3;
      Hall3:   nxt = Hall4;
      Hall4:   nxt = Hall5;
      Hall5:   nxt = Hall0;
      default: nxt = code;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_speed_chan.sv
// One Hall channel: per-bit debouncer, tracking FSM, period averaging and a
// single-entry result slot. Stall detection is built in with MC_SPEED_STALL_EN.
module mc_speed_chan
  import mc_speed_pkg::*;
#(
`ifdef MC_SPEED_STALL_EN
  parameter logic [31:0] STALL_CYC = 32'd50_000_000,
`endif
  parameter int unsigned DEB_LEN  = 400,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [2:0]       raw,
  output logic [2:0]       pos,
  input  logic             take,
  output logic             pend_valid,
  output logic [CNT_W-1:0] pend_period,
  output logic             pend_dir,
  output logic             pend_stall,
  output logic             err
);

  localparam int unsigned DebW  = $clog2(DEB_LEN);
  localparam int unsigned AccW  = CNT_W + AVG_LOG2;
  localparam int unsigned EdgeW = AVG_LOG2 + 1;
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_LEN - 1);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'((1 << AVG_LOG2) - 1);
`ifdef MC_SPEED_STALL_EN
  localparam logic [CNT_W-1:0] StallCnt = CNT_W'(STALL_CYC);
`endif

  logic [DebW-1:0]  deb_cnt_q [3];
  logic [2:0]       pos_q, prev_q;
  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, post_period;
  logic [AccW-1:0]  acc_q, acc_d, acc_sum;
  logic [EdgeW-1:0] edge_q, edge_d;
  logic             dir_q, dir_d;
  logic             chg, new_ok, old_ok, is_fwd, is_rev, adj;
  logic             post, post_stall, bad;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pos_q <= '0;
      for (int b = 0; b < 3; b++) deb_cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (raw[b] == pos_q[b]) begin
          deb_cnt_q[b] <= '0;
        end else if (deb_cnt_q[b] == DebLast) begin
          pos_q[b]     <= raw[b];
          deb_cnt_q[b] <= '0;
        end else begin
          deb_cnt_q[b] <= deb_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  assign pos     = pos_q;
  assign chg     = pos_q != prev_q;
  assign new_ok  = code_valid(pos_q);
  assign old_ok  = code_valid(prev_q);
  assign is_fwd  = fwd_next(prev_q) == pos_q;
  assign is_rev  = fwd_next(pos_q) == prev_q;
  assign adj     = new_ok && old_ok && (is_fwd || is_rev);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign acc_sum = acc_q + AccW'(cnt_inc);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    edge_d      = edge_q;
    dir_d       = dir_q;
    post        = 1'b0;
    post_period = '0;
    post_stall  = 1'b0;
    bad         = 1'b0;
    if (state_q == StSync || state_q == StRun) cnt_d = cnt_inc;
    if (chg) begin
      if (!new_ok || (old_ok && !adj)) begin
        bad     = 1'b1;
        state_d = StIdle;
        cnt_d   = '0;
        acc_d   = '0;
        edge_d  = '0;
      end else begin
        cnt_d = '0;
        case (state_q)
          StIdle: state_d = StSync;
          StSync: begin
            state_d = StRun;
            dir_d   = is_fwd;
            acc_d   = '0;
            edge_d  = '0;
          end
          StRun: begin
            if (is_fwd != dir_q) begin
              state_d = StSync;
              acc_d   = '0;
              edge_d  = '0;
            end else if (edge_q == LastEdge) begin
              post        = 1'b1;
              post_period = CNT_W'(acc_sum >> AVG_LOG2);
              acc_d       = '0;
              edge_d      = '0;
            end else begin
              acc_d  = acc_sum;
              edge_d = edge_q + 1'b1;
            end
          end
`ifdef MC_SPEED_STALL_EN
          StStall: state_d = StSync;
`endif
          default: state_d = StIdle;
        endcase
      end
    end
`ifdef MC_SPEED_STALL_EN
    else if ((state_q == StSync || state_q == StRun) && cnt_inc == StallCnt) begin
      post        = 1'b1;
      post_period = '1;
      post_stall  = 1'b1;
      state_d     = StStall;
      acc_d       = '0;
      edge_d      = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prev_q      <= '0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      edge_q      <= '0;
      dir_q       <= 1'b0;
      pend_valid  <= 1'b0;
      pend_period <= '0;
      pend_dir    <= 1'b0;
      pend_stall  <= 1'b0;
      err         <= 1'b0;
    end else begin
      prev_q  <= pos_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      edge_q  <= edge_d;
      dir_q   <= dir_d;
      // A post in the same cycle as the arbiter taking the slot is a clean refill.
      if (post) begin
        pend_valid  <= 1'b1;
        pend_period <= post_period;
        pend_dir    <= dir_q;
        pend_stall  <= post_stall;
      end else if (take) begin
        pend_valid <= 1'b0;
      end
      if (bad || (post && pend_valid && !take)) err <= 1'b1;
    end
  end

endmodule

// File: rtl/mc_speed_core.sv
// Multi-channel Hall speed core with round-robin result output.
// Define MC_SPEED_STALL_EN to build in stall detection.
module mc_speed_core
  import mc_speed_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DEB_LEN   = 400,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned AVG_LOG2  = 2,
  parameter logic [31:0] STALL_CYC = 32'd50_000_000
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [3*NUM_CH-1:0] position_i,
  output logic [3*NUM_CH-1:0] position_o,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [1:0]          m_ch,
  output logic [CNT_W-1:0]    m_period,
  output logic                m_dir,
  output logic                m_stall,
  output logic [NUM_CH-1:0]   err_o
);

  logic [NUM_CH-1:0] pend_valid, pend_dir, pend_stall, take;
  logic [CNT_W-1:0]  pend_period [NUM_CH];
  logic [1:0]        start_q, gnt, nxt_start;
  logic              out_free, found, sel_dir, sel_stall;
  logic [CNT_W-1:0]  sel_period;

`ifndef MC_SPEED_STALL_EN
  logic unused_stall_cyc;
  assign unused_stall_cyc = ^STALL_CYC;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mc_speed_chan #(
`ifdef MC_SPEED_STALL_EN
      .STALL_CYC(STALL_CYC),
`endif
      .DEB_LEN (DEB_LEN),
      .CNT_W   (CNT_W),
      .AVG_LOG2(AVG_LOG2)
    ) u_chan (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .raw        (position_i[3*c +: 3]),
      .pos        (position_o[3*c +: 3]),
      .take       (take[c]),
      .pend_valid (pend_valid[c]),
      .pend_period(pend_period[c]),
      .pend_dir   (pend_dir[c]),
      .pend_stall (pend_stall[c]),
      .err        (err_o[c])
    );
  end

  // Two passes: channels from start_q upward, then wrap around to the rest.
  always_comb begin
    found      = 1'b0;
    gnt        = '0;
    sel_period = '0;
    sel_dir    = 1'b0;
    sel_stall  = 1'b0;
    out_free   = !m_valid || m_ready;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!found && pend_valid[j] && (32'(j) >= 32'(start_q))) begin
        found      = 1'b1;
        gnt        = 2'(j);
        sel_period = pend_period[j];
        sel_dir    = pend_dir[j];
        sel_stall  = pend_stall[j];
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (!found && pend_valid[j]) begin
        found      = 1'b1;
        gnt        = 2'(j);
        sel_period = pend_period[j];
        sel_dir    = pend_dir[j];
        sel_stall  = pend_stall[j];
      end
    end
    take = '0;
    for (int j = 0; j < NUM_CH; j++) take[j] = out_free && found && (gnt == 2'(j));
    nxt_start = (32'(gnt) + 32'd1 >= NUM_CH) ? 2'd0 : gnt + 2'd1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_valid  <= 1'b0;
      m_ch     <= '0;
      m_period <= '0;
      m_dir    <= 1'b0;
      m_stall  <= 1'b0;
      start_q  <= '0;
    end else if (out_free) begin
      m_valid <= found;
      if (found) begin
        m_ch     <= gnt;
        m_period <= sel_period;
        m_dir    <= sel_dir;
        m_stall  <= sel_stall;
        start_q  <= nxt_start;
      end
    end
  end

endmodule

// File: tb/tb_mc_speed_core.sv
// Directed self-checking bench for mc_speed_core (2 channels, short debounce).
module tb_mc_speed_core;

  logic        clk = 1'b0;
  logic        rstn;
  logic [5:0]  position_i;
  logic [5:0]  position_o;
  logic        m_valid, m_ready;
  logic [1:0]  m_ch;
  logic [31:0] m_period;
  logic        m_dir, m_stall;
  logic [1:0]  err_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] period;
    logic        dir;
    logic        stall;
  } res_t;

  res_t        rq[$];
  logic [2:0]  fwd [6];
  logic [2:0]  rev [6];

  always #5 clk = ~clk;

  mc_speed_core #(
    .NUM_CH   (2),
    .DEB_LEN  (4),
    .CNT_W    (32),
    .AVG_LOG2 (2),
    .STALL_CYC(32'd1000)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .position_i(position_i),
    .position_o(position_o),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_ch      (m_ch),
    .m_period  (m_period),
    .m_dir     (m_dir),
    .m_stall   (m_stall),
    .err_o     (err_o)
  );

  always @(negedge clk) begin
    if (rstn === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1)
      rq.push_back({m_ch, m_period, m_dir, m_stall});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [2:0] code);
    position_i[3*c +: 3] = code;
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    position_i = '0;
    m_ready    = 1'b1;
    cycles(2);
    rq.delete();
    rstn = 1'b1;
    cycles(1);
  endtask

  task automatic wait_pos(input int c, input logic [2:0] code, input string tag);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (position_o[3*c +: 3] === code) break;
    end
    chk(tag, position_o[3*c +: 3], code);
  endtask

  task automatic chk_res(input string tag, input int j, input logic [1:0] ch,
                         input logic [31:0] period, input logic dir, input logic stall);
    res_t r;
    r = '1;
    if (j < rq.size()) r = rq[j];
    chk({tag, "_ch"}, r.ch, ch);
    chk({tag, "_period"}, r.period, period);
    chk({tag, "_dir"}, r.dir, dir);
    chk({tag, "_stall"}, r.stall, stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    fwd = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    rev = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011};

    // Reset state
    rstn       = 1'b0;
    position_i = '0;
    m_ready    = 1'b1;
    cycles(3);
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_ch", m_ch, 0);
    chk("rst_period", m_period, 0);
    chk("rst_dir", m_dir, 0);
    chk("rst_stall", m_stall, 0);
    chk("rst_err", err_o, 0);
    chk("rst_pos", position_o, 0);

    // Ch0 forward, 100 cycles per step, with output latency
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_ch(0, fwd[i]);
      if (i < 5) cycles(100);
    end
    wait_pos(0, 3'b101, "a_pos");
    @(negedge clk);
    chk("a_lat1_valid", m_valid, 0);
    @(negedge clk);
    chk("a_lat2_valid", m_valid, 1);
    chk("a_ch", m_ch, 0);
    chk("a_period", m_period, 100);
    chk("a_dir", m_dir, 1);
    chk("a_stall", m_stall, 0);
    chk("a_err", err_o, 0);

    // Ch0 reverse and ch1 forward together; arbiter alternates
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_ch(0, rev[i % 6]);
      set_ch(1, fwd[i % 6]);
      cycles(100);
    end
    chk("b_count", rq.size(), 4);
    for (int j = 0; j < 4; j++)
      chk_res($sformatf("b_res%0d", j), j, 2'(j % 2), 32'd100, (j % 2) == 1, 1'b0);
    chk("b_err", err_o, 0);

    // 3-cycle glitch is filtered
    do_reset();
    set_ch(0, 3'b001);
    cycles(20);
    set_ch(0, 3'b000);
    cycles(3);
    set_ch(0, 3'b001);
    cycles(20);
    chk("c_pos", position_o[2:0], 3'b001);
    chk("c_err", err_o, 0);
    for (int i = 1; i < 6; i++) begin
      set_ch(0, fwd[i]);
      cycles(100);
    end
    chk("c_count", rq.size(), 1);
    chk_res("c_res", 0, 2'd0, 32'd100, 1'b1, 1'b0);

    // Invalid code 111 -> sticky error and resync
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_ch(0, fwd[i]);
      cycles(100);
    end
    set_ch(0, 3'b111);
    cycles(10);
    chk("d_err", err_o, 2'b01);
    for (int i = 3; i < 8; i++) begin
      set_ch(0, fwd[i % 6]);
      cycles(100);
    end
    chk("d_count_before", rq.size(), 0);
    set_ch(0, fwd[2]);
    cycles(100);
    chk("d_count_after", rq.size(), 1);
    chk_res("d_res", 0, 2'd0, 32'd100, 1'b1, 1'b0);
    chk("d_err_sticky", err_o, 2'b01);

    // Backpressure: held output, overwritten pending slot
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      hold = (i < 5) ? 100 : (i < 9) ? 60 : (i < 13) ? 80 : 20;
      if (i == 13) begin
        chk("e_mid_valid", m_valid, 1);
        chk("e_mid_period", m_period, 100);
        chk("e_mid_err", err_o, 0);
      end
      set_ch(0, fwd[i % 6]);
      cycles(hold);
    end
    chk("e_end_valid", m_valid, 1);
    chk("e_end_period", m_period, 100);
    chk("e_end_ch", m_ch, 0);
    chk("e_end_err", err_o, 2'b01);
    m_ready = 1'b1;
    cycles(5);
    chk("e_count", rq.size(), 2);
    chk_res("e_res0", 0, 2'd0, 32'd100, 1'b1, 1'b0);
    chk_res("e_res1", 1, 2'd0, 32'd80, 1'b1, 1'b0);

`ifdef MC_SPEED_STALL_EN
    // Stall report after 1000 idle cycles in RUN, then resync
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_ch(0, fwd[i]);
      cycles(100);
    end
    cycles(1000);
    chk("f_count", rq.size(), 1);
    chk_res("f_stall", 0, 2'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    cycles(1500);
    chk("f_count_once", rq.size(), 1);
    for (int i = 3; i < 8; i++) begin
      set_ch(0, fwd[i % 6]);
      cycles(100);
    end
    chk("f_count_resync", rq.size(), 1);
    set_ch(0, fwd[2]);
    cycles(100);
    chk("f_count_after", rq.size(), 2);
    chk_res("f_res", 1, 2'd0, 32'd100, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
